// File: rtl/amber48_fetch_unit.sv
// Amber48 fetch unit: sequential PC generation, in-order imem response tracking and an
// instruction queue with redirect flush. Define AMBER48_FETCH_BYPASS_EN for the same-cycle response bypass.
module amber48_fetch_unit #(
  parameter int unsigned     XLEN            = 48,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     BAU_BYTES       = XLEN / 8,
  parameter logic [XLEN-1:0] PC_INC          = XLEN'(BAU_BYTES)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clk_en_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic                       imem_ready_i,
  input  logic                       imem_valid_i,
  input  logic [XLEN-1:0]            imem_data_i,
  input  logic                       imem_err_i,
  output logic                       fetch_valid_o,
  output logic [XLEN-1:0]            fetch_pc_o,
  output logic [XLEN-1:0]            fetch_instr_o,
  output logic                       fetch_fault_o,
  input  logic                       fetch_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = $clog2(2 * DEPTH + 1);

  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OCC_W-1:0] FULL    = OCC_W'(DEPTH);
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } entry_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] drop_q, drop_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  entry_t           mem_q [DEPTH];

  logic [SUM_W-1:0] in_flight;
  logic             flush, req_acc, rsp_fire, rsp_drop, rsp_keep;
  logic             q_valid, bypass, push, pop;
  entry_t           head, rsp_entry, out_entry;

  // Requests are throttled so every in-flight response is guaranteed a queue slot.
  always_comb begin
    in_flight  = SUM_W'(occ_q) + SUM_W'(out_q);
    imem_req_o = rst_ni & clk_en_i & ~redirect_i & (out_q < MAX_OUT) & (in_flight < DEPTH_S);
  end

  assign imem_addr_o = pc_q;
  assign flush       = clk_en_i & redirect_i;
  assign req_acc     = imem_req_o & imem_ready_i;
  assign rsp_fire    = clk_en_i & imem_valid_i;
  assign rsp_drop    = rsp_fire & (redirect_i | (drop_q != '0));
  assign rsp_keep    = rsp_fire & ~rsp_drop;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    q_valid   = (occ_q != '0);
    rsp_entry = '{pc: rsp_pc_q, instr: imem_data_i, fault: imem_err_i};
    bypass    = 1'b0;
`ifdef AMBER48_FETCH_BYPASS_EN
    bypass    = rsp_keep & ~q_valid;
`endif
    if (bypass)       out_entry = rsp_entry;
    else if (q_valid) out_entry = head;
    else              out_entry = '0;
    fetch_valid_o = q_valid | bypass;
    fetch_pc_o    = out_entry.pc;
    fetch_instr_o = out_entry.instr;
    fetch_fault_o = out_entry.fault;
    // A bypassed response that decode takes immediately never occupies a slot.
    push = rsp_keep & ~(bypass & fetch_ready_i);
    pop  = q_valid & fetch_ready_i & clk_en_i & ~flush;
  end

  assign occupancy_o = occ_q;

  // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      pc_d     = redirect_pc_i;
      rsp_pc_d = redirect_pc_i;
      drop_d   = out_q - OUT_W'(rsp_fire);
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (req_acc)  pc_d     = pc_q + PC_INC;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + PC_INC;
      if (rsp_drop) drop_d   = drop_q - OUT_W'(1);
      if (push)     wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
    out_d = out_q + OUT_W'(req_acc) - OUT_W'(rsp_fire);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: payload storage is not reset; occupancy and pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rsp_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(rsp_fire && out_q == '0))
        else $error("imem response with no request outstanding");
      assert (!(push && occ_q == FULL && !pop))
        else $error("instruction queue overflow");
      assert (out_q <= MAX_OUT)
        else $error("outstanding count above limit");
    end
  end

endmodule

// File: tb/tb_amber48_fetch_unit.sv
// Directed bench for amber48_fetch_unit: 1-cycle imem model, expected-instruction scoreboard
// with epoch-style stale marking on redirect, and targeted checks of reset, fill, flush and wrap.
module tb_amber48_fetch_unit;

  localparam int unsigned     XLEN     = 48;
  localparam logic [XLEN-1:0] RESET_PC = '0;
`ifdef AMBER48_FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef logic [XLEN-1:0] word_t;
  typedef struct { word_t addr; bit stale; } req_t;
  typedef struct { word_t pc; word_t instr; bit fault; } exp_t;

  logic       clk, rst_n, clk_en, redirect, imem_ready, imem_valid, imem_err, fetch_ready;
  word_t      redirect_pc, imem_data;
  logic       imem_req_o, fetch_valid_o, fetch_fault_o;
  word_t      imem_addr_o, fetch_pc_o, fetch_instr_o;
  logic [2:0] occupancy_o;

  req_t  pending [$];
  exp_t  exp_q   [$];
  word_t log_pc  [$];
  bit    log_fault [$];
  word_t log_req [$];

  int    checks, errors, n_consumed, mark, mark_r;
  bit    rsp_en;
  word_t err_addr;

  logic       snap_req, snap_fvalid, snap_fault;
  word_t      snap_addr, snap_pc, snap_instr;
  logic [2:0] snap_occ;

  amber48_fetch_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clk_en_i      (clk_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready),
    .imem_valid_i  (imem_valid),
    .imem_data_i   (imem_data),
    .imem_err_i    (imem_err),
    .fetch_valid_o (fetch_valid_o),
    .fetch_pc_o    (fetch_pc_o),
    .fetch_instr_o (fetch_instr_o),
    .fetch_fault_o (fetch_fault_o),
    .fetch_ready_i (fetch_ready),
    .occupancy_o   (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t instr_of(input word_t a);
    return a ^ 48'h5A5A_C3C3_0F0F;
  endfunction

  function automatic word_t pc_at(input int i);
    if (i < log_pc.size()) return log_pc[i];
    return '1;
  endfunction

  function automatic logic fault_at(input int i);
    if (i < log_fault.size()) return log_fault[i];
    return 1'bx;
  endfunction

  function automatic word_t req_at(input int i);
    if (i < log_req.size()) return log_req[i];
    return '1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle, entered and left at posedge+1: drive the memory response, sample at
  // posedge+4, update the model for what the coming edge commits.
  task automatic cycle();
    req_t p;
    exp_t e;
    if (rsp_en && pending.size() > 0) begin
      imem_valid = 1'b1;
      imem_data  = instr_of(pending[0].addr);
      imem_err   = (pending[0].addr == err_addr);
    end else begin
      imem_valid = 1'b0;
      imem_data  = '0;
      imem_err   = 1'b0;
    end
    #3;
    snap_req    = imem_req_o;
    snap_addr   = imem_addr_o;
    snap_fvalid = fetch_valid_o;
    snap_pc     = fetch_pc_o;
    snap_instr  = fetch_instr_o;
    snap_fault  = fetch_fault_o;
    snap_occ    = occupancy_o;
    if (rst_n && clk_en) begin
      if (redirect) begin
        foreach (pending[i]) pending[i].stale = 1'b1;
        exp_q.delete();
      end
      if (imem_valid) begin
        p = pending.pop_front();
        if (!p.stale) exp_q.push_back('{pc: p.addr, instr: instr_of(p.addr), fault: (p.addr == err_addr)});
      end
      if (fetch_valid_o && fetch_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          check("spurious_fetch", 64'(fetch_valid_o), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", 64'(fetch_pc_o), 64'(e.pc));
          check("sb_instr", 64'(fetch_instr_o), 64'(e.instr));
          check("sb_fault", 64'(fetch_fault_o), 64'(e.fault));
          log_pc.push_back(fetch_pc_o);
          log_fault.push_back(fetch_fault_o);
          n_consumed++;
        end
      end
      if (imem_req_o && imem_ready) begin
        pending.push_back('{addr: imem_addr_o, stale: 1'b0});
        log_req.push_back(imem_addr_o);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; n_consumed = 0;
    rsp_en = 1'b1; err_addr = 48'h18;
    rst_n = 1'b0; clk_en = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b1; imem_valid = 1'b0; imem_data = '0; imem_err = 1'b0; fetch_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    cycle();
    cycle();
    check("rst_req", 64'(snap_req), 64'(0));
    check("rst_addr", 64'(snap_addr), 64'(RESET_PC));
    check("rst_fvalid", 64'(snap_fvalid), 64'(0));
    check("rst_fault", 64'(snap_fault), 64'(0));
    check("rst_pc", 64'(snap_pc), 64'(0));
    check("rst_instr", 64'(snap_instr), 64'(0));
    check("rst_occ", 64'(snap_occ), 64'(0));

    // Streaming from reset with a fault on 0x18
    rst_n = 1'b1;
    cycle();
    check("first_req", 64'(snap_req), 64'(1));
    check("first_addr", 64'(snap_addr), 64'(RESET_PC));
    cycle();
    check("rsp_latency_n", 64'(snap_fvalid), 64'(BYPASS));
    cycle();
    check("rsp_latency_n1", 64'(snap_fvalid), 64'(1));
    mark = n_consumed;
    repeat (8) cycle();
    check("stream_rate", 64'(n_consumed - mark), 64'(8));
    check("seq_pc1", 64'(pc_at(1)), 64'h6);
    check("seq_pc2", 64'(pc_at(2)), 64'hC);
    check("fault_pc", 64'(pc_at(4)), 64'h18);
    check("fault_flag", 64'(fault_at(4)), 64'(1));
    check("after_fault_pc", 64'(pc_at(5)), 64'h1E);
    check("after_fault_flag", 64'(fault_at(5)), 64'(0));

    // Decode stalled: queue fills to DEPTH and requests stop
    fetch_ready = 1'b0;
    repeat (8) cycle();
    check("full_occ", 64'(snap_occ), 64'(4));
    check("full_req", 64'(snap_req), 64'(0));
    check("full_fvalid", 64'(snap_fvalid), 64'(1));

    // Clock enable low: nothing moves even with decode ready
    clk_en = 1'b0;
    fetch_ready = 1'b1;
    repeat (3) begin
      cycle();
      check("hold_req", 64'(snap_req), 64'(0));
      check("hold_occ", 64'(snap_occ), 64'(4));
      if (exp_q.size() > 0) check("hold_pc", 64'(snap_pc), 64'(exp_q[0].pc));
    end
    clk_en = 1'b1;
    mark = n_consumed;
    repeat (4) cycle();
    check("drain_count", 64'(n_consumed - mark), 64'(4));

    // Redirect with two requests outstanding: both late responses are discarded
    rsp_en = 1'b0;
    repeat (6) cycle();
    check("stall_req", 64'(snap_req), 64'(0));
    check("stall_occ", 64'(snap_occ), 64'(0));
    redirect = 1'b1;
    redirect_pc = 48'h100;
    cycle();
    check("redirect_req", 64'(snap_req), 64'(0));
    redirect = 1'b0;
    rsp_en = 1'b1;
    mark = log_pc.size();
    repeat (6) cycle();
    check("redirect_pc0", 64'(pc_at(mark)), 64'h100);
    check("redirect_pc1", 64'(pc_at(mark + 1)), 64'h106);

    // Redirect over a partly filled queue to the top of the address space; PC wraps to 0
    fetch_ready = 1'b0;
    repeat (2) cycle();
    redirect = 1'b1;
    redirect_pc = 48'hFFFF_FFFF_FFFA;
    fetch_ready = 1'b1;
    cycle();
    check("flush_cycle_req", 64'(snap_req), 64'(0));
    redirect = 1'b0;
    mark_r = log_req.size();
    mark = log_pc.size();
    cycle();
    check("flush_occ", 64'(snap_occ), 64'(0));
    repeat (5) cycle();
    check("wrap_req0", 64'(req_at(mark_r)), 64'hFFFF_FFFF_FFFA);
    check("wrap_req1", 64'(req_at(mark_r + 1)), 64'h0);
    check("wrap_pc0", 64'(pc_at(mark)), 64'hFFFF_FFFF_FFFA);
    check("wrap_pc1", 64'(pc_at(mark + 1)), 64'h0);

    // Reset in the middle of traffic abandons everything in flight
    rst_n = 1'b0;
    pending.delete();
    exp_q.delete();
    cycle();
    check("midrst_req", 64'(snap_req), 64'(0));
    check("midrst_fvalid", 64'(snap_fvalid), 64'(0));
    check("midrst_occ", 64'(snap_occ), 64'(0));
    rst_n = 1'b1;
    cycle();
    check("midrst_first_req", 64'(snap_req), 64'(1));
    check("midrst_first_addr", 64'(snap_addr), 64'(RESET_PC));
    mark = log_pc.size();
    repeat (4) cycle();
    check("midrst_pc0", 64'(pc_at(mark)), 64'(RESET_PC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
